// File: rtl/note_display_scan.sv
// note_display_scan: decodes the played frequency (octaves 3-5) into note letter,
// sharp flag and octave, commits it through a stability filter, and scans it
// across NUM_DIGITS common-anode seven-segment digits (active-low an/seg/dp).
module note_display_scan #(
   parameter int NUM_DIGITS    = 4,
   parameter int FREQ_W        = 12,
   parameter int SCAN_DIV      = 100000,
   parameter int STABLE_CYCLES = 1000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [FREQ_W-1:0]     freq,
   input  logic                  blank,
   output logic [NUM_DIGITS-1:0] an,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic                  note_strobe
);

   localparam int IDX_W  = $clog2(NUM_DIGITS);
   localparam int SCAN_W = $clog2(SCAN_DIV);
   localparam int STAB_W = $clog2(STABLE_CYCLES);

   // Octave 3, 4, 5 frequencies, each in note order C, C#, D ... B.
   localparam int unsigned FREQ_TAB [36] = '{
      131, 139, 147, 156, 165, 175, 185, 196, 208, 220, 233, 247,
      261, 277, 293, 311, 330, 349, 370, 392, 415, 440, 466, 494,
      523, 554, 587, 622, 659, 698, 740, 784, 831, 880, 932, 988
   };

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   typedef struct packed {
      logic       valid;
      logic [2:0] octave;
      logic [3:0] note;
   } note_code_t;

   localparam note_code_t NOTE_NONE = '0;

   note_code_t          decoded;
   note_code_t          pending;
   note_code_t          committed;
   logic [STAB_W-1:0]   stab_cnt;
   logic [SCAN_W-1:0]   scan_cnt;
   logic [IDX_W-1:0]    digit_idx;
   logic [6:0]          seg_d;
   logic                dp_d;
   logic [6:0]          letter;
   logic                sharp;

   // Exact-match lookup of the frequency against the note table.
   always_comb begin
      decoded = NOTE_NONE;
      for (int unsigned i = 0; i < 36; i++) begin
         if (freq == FREQ_W'(FREQ_TAB[i])) begin
            decoded.valid  = 1'b1;
            decoded.octave = 3'(3 + i / 12);
            decoded.note   = 4'(i % 12);
         end
      end
   end

   // Stability filter: restart the window on any decode change, commit when it
   // has held long enough; strobe only when the committed value actually changes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending     <= NOTE_NONE;
         committed   <= NOTE_NONE;
         stab_cnt    <= '0;
         note_strobe <= 1'b0;
      end else begin
         note_strobe <= 1'b0;
         if (decoded != pending) begin
            pending  <= decoded;
            stab_cnt <= '0;
         end else if (stab_cnt == STAB_W'(STABLE_CYCLES - 1)) begin
            committed   <= pending;
            note_strobe <= (pending != committed);
         end else begin
            stab_cnt <= stab_cnt + 1'b1;
         end
      end
   end

   // Digit scan: each digit held for SCAN_DIV cycles, wrapping over NUM_DIGITS.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt  <= '0;
         digit_idx <= '0;
      end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
         scan_cnt  <= '0;
         digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   // Note letter and sharp flag from the committed note index.
   always_comb begin
      letter = SEG_BLANK;
      sharp  = 1'b0;
      case (committed.note)
         4'd0:  letter = 7'b1000110;
         4'd1:  begin letter = 7'b1000110; sharp = 1'b1; end
         4'd2:  letter = 7'b0100001;
         4'd3:  begin letter = 7'b0100001; sharp = 1'b1; end
         4'd4:  letter = 7'b0000110;
         4'd5:  letter = 7'b0001110;
         4'd6:  begin letter = 7'b0001110; sharp = 1'b1; end
         4'd7:  letter = 7'b0010000;
         4'd8:  begin letter = 7'b0010000; sharp = 1'b1; end
         4'd9:  letter = 7'b0001000;
         4'd10: begin letter = 7'b0001000; sharp = 1'b1; end
         4'd11: letter = 7'b0000011;
         default: letter = SEG_BLANK;
      endcase
   end

   // Content of the currently selected digit.
   always_comb begin
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
      if (!committed.valid) begin
         if (digit_idx == '0) seg_d = SEG_DASH;
      end else if (digit_idx == '0) begin
         seg_d = letter;
         dp_d  = ~sharp;
      end else if (digit_idx == IDX_W'(1)) begin
         case (committed.octave)
            3'd3:    seg_d = 7'b0110000;
            3'd4:    seg_d = 7'b0011001;
            3'd5:    seg_d = 7'b0010010;
            default: seg_d = SEG_BLANK;
         endcase
      end
   end

   // Pin register: an/seg/dp load together so no digit/segment mix is visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an  <= '1;
         seg <= '1;
         dp  <= 1'b1;
      end else if (blank) begin
         an  <= '1;
         seg <= '1;
         dp  <= 1'b1;
      end else begin
         an  <= ~(NUM_DIGITS'(1) << digit_idx);
         seg <= seg_d;
         dp  <= dp_d;
      end
   end

endmodule

// File: tb/tb_note_display_scan.sv
// Directed bench for note_display_scan with SCAN_DIV=4, STABLE_CYCLES=8, NUM_DIGITS=4.
module tb_note_display_scan;

   localparam int ND = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [11:0]   freq = '0;
   logic          blank = 1'b0;
   logic [ND-1:0] an;
   logic [6:0]    seg;
   logic          dp;
   logic          note_strobe;

   int checks = 0;
   int errors = 0;

   localparam logic [6:0] S_BLANK = 7'b1111111;
   localparam logic [6:0] S_DASH  = 7'b0111111;
   localparam logic [6:0] S_A     = 7'b0001000;
   localparam logic [6:0] S_C     = 7'b1000110;
   localparam logic [6:0] S_4     = 7'b0011001;
   localparam logic [6:0] S_5     = 7'b0010010;

   note_display_scan #(
      .NUM_DIGITS(ND),
      .FREQ_W(12),
      .SCAN_DIV(4),
      .STABLE_CYCLES(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .freq(freq),
      .blank(blank),
      .an(an),
      .seg(seg),
      .dp(dp),
      .note_strobe(note_strobe)
   );

   always #5 clk = ~clk;

   // Advance to the first negedge sample where digit d is lit (bounded).
   task automatic wait_digit(input int d);
      logic [ND-1:0] exp_an;
      bit found;
      exp_an = ~(4'b0001 << d);
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (an === exp_an) found = 1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL wait_digit%0d: an=%b never reached %b", d, an, exp_an);
      end
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #1;
      checks++;
      if (an !== 4'b1111 || seg !== S_BLANK || dp !== 1'b1 || note_strobe !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: an=%b seg=%b dp=%b strobe=%b want 1111 1111111 1 0",
                  an, seg, dp, note_strobe);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (an !== 4'b1111 || seg !== S_BLANK) begin
         errors++;
         $display("FAIL reset_hold: an=%b seg=%b want 1111 1111111", an, seg);
      end
      rst = 1'b0;
   endtask

   task automatic test_scan_idle();
      logic [ND-1:0] exp_an;
      logic [6:0]    exp_seg;
      int            idx;
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         idx     = ((k - 1) / 4) % 4;
         exp_an  = ~(4'b0001 << idx);
         exp_seg = (idx == 0) ? S_DASH : S_BLANK;
         checks++;
         if (an !== exp_an || seg !== exp_seg || dp !== 1'b1 || note_strobe !== 1'b0) begin
            errors++;
            $display("FAIL scan_idle k=%0d: an=%b seg=%b dp=%b strobe=%b want %b %b 1 0",
                     k, an, seg, dp, note_strobe, exp_an, exp_seg);
         end
      end
   endtask

   task automatic test_commit_a4();
      int n, at;
      n = 0; at = 0;
      freq = 12'd440;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         if (note_strobe === 1'b1) begin n++; at = i; end
      end
      checks++;
      if (n !== 1 || at !== 9) begin
         errors++;
         $display("FAIL a4_strobe: count=%0d at=%0d want count=1 at=9", n, at);
      end
      wait_digit(0);
      checks++;
      if (seg !== S_A || dp !== 1'b1) begin
         errors++;
         $display("FAIL a4_digit0: seg=%b dp=%b want %b 1", seg, dp, S_A);
      end
      wait_digit(1);
      checks++;
      if (seg !== S_4 || dp !== 1'b1) begin
         errors++;
         $display("FAIL a4_digit1: seg=%b dp=%b want %b 1", seg, dp, S_4);
      end
   endtask

   task automatic test_sharp_cs5();
      int n;
      n = 0;
      freq = 12'd554;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         if (note_strobe === 1'b1) n++;
      end
      checks++;
      if (n !== 1) begin
         errors++;
         $display("FAIL cs5_strobe: count=%0d want 1", n);
      end
      wait_digit(0);
      checks++;
      if (seg !== S_C || dp !== 1'b0) begin
         errors++;
         $display("FAIL cs5_digit0: seg=%b dp=%b want %b 0", seg, dp, S_C);
      end
      wait_digit(1);
      checks++;
      if (seg !== S_5 || dp !== 1'b1) begin
         errors++;
         $display("FAIL cs5_digit1: seg=%b dp=%b want %b 1", seg, dp, S_5);
      end
   endtask

   task automatic test_glitch();
      int n;
      // Re-establish A4 as the committed note.
      freq = 12'd440;
      repeat (14) @(negedge clk);
      n = 0;
      freq = 12'd466;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (note_strobe === 1'b1) n++;
      end
      freq = 12'd440;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (note_strobe === 1'b1) n++;
      end
      checks++;
      if (n !== 0) begin
         errors++;
         $display("FAIL glitch_strobe: count=%0d want 0", n);
      end
      wait_digit(0);
      checks++;
      if (seg !== S_A || dp !== 1'b1) begin
         errors++;
         $display("FAIL glitch_digit0: seg=%b dp=%b want %b 1", seg, dp, S_A);
      end
      wait_digit(1);
      checks++;
      if (seg !== S_4) begin
         errors++;
         $display("FAIL glitch_digit1: seg=%b want %b", seg, S_4);
      end
   endtask

   task automatic test_invalid();
      int n, at;
      n = 0; at = 0;
      freq = 12'd300;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         if (note_strobe === 1'b1) begin n++; at = i; end
      end
      checks++;
      if (n !== 1 || at !== 9) begin
         errors++;
         $display("FAIL none_strobe: count=%0d at=%0d want count=1 at=9", n, at);
      end
      wait_digit(0);
      checks++;
      if (seg !== S_DASH || dp !== 1'b1) begin
         errors++;
         $display("FAIL none_digit0: seg=%b dp=%b want %b 1", seg, dp, S_DASH);
      end
      wait_digit(1);
      checks++;
      if (seg !== S_BLANK || dp !== 1'b1) begin
         errors++;
         $display("FAIL none_digit1: seg=%b dp=%b want %b 1", seg, dp, S_BLANK);
      end
   endtask

   task automatic test_blank();
      wait_digit(1);
      wait_digit(2);   // first of the four cycles on digit 2
      blank = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (an !== 4'b1111 || seg !== S_BLANK || dp !== 1'b1) begin
            errors++;
            $display("FAIL blank_on%0d: an=%b seg=%b dp=%b want 1111 1111111 1", i, an, seg, dp);
         end
      end
      blank = 1'b0;
      @(negedge clk);
      checks++;
      if (an !== 4'b1011) begin
         errors++;
         $display("FAIL blank_release: an=%b want 1011", an);
      end
      @(negedge clk);
      checks++;
      if (an !== 4'b0111) begin
         errors++;
         $display("FAIL blank_next: an=%b want 0111", an);
      end
   endtask

   task automatic test_reset_mid_window();
      int n, at;
      freq = 12'd440;
      repeat (5) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      checks++;
      if (an !== 4'b1111 || seg !== S_BLANK || dp !== 1'b1 || note_strobe !== 1'b0) begin
         errors++;
         $display("FAIL midrst_async: an=%b seg=%b dp=%b strobe=%b want 1111 1111111 1 0",
                  an, seg, dp, note_strobe);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (an !== 4'b1110 || seg !== S_DASH || dp !== 1'b1) begin
         errors++;
         $display("FAIL midrst_first: an=%b seg=%b dp=%b want 1110 %b 1", an, seg, dp, S_DASH);
      end
      n = 0; at = 0;
      if (note_strobe === 1'b1) begin n++; at = 1; end
      for (int i = 2; i <= 14; i++) begin
         @(negedge clk);
         if (note_strobe === 1'b1) begin n++; at = i; end
      end
      checks++;
      if (n !== 1 || at !== 9) begin
         errors++;
         $display("FAIL midrst_commit: count=%0d at=%0d want count=1 at=9", n, at);
      end
   endtask

   initial begin
      test_reset();
      test_scan_idle();
      test_commit_a4();
      test_sharp_cs5();
      test_glitch();
      test_invalid();
      test_blank();
      test_reset_mid_window();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
